prime_generator: RTL and testbench

PRIME_GENERATOR -- requirements
Module: prime_generator

---
 rtl/prime_pkg.sv | 5 +
 rtl/prime_mod_unit.sv | 48 ++++
 rtl/prime_generator.sv | 91 +++++++++
 tb/tb_prime_generator.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// prime_pkg: shared width default and FSM state encoding for the prime generator
package prime_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [2:0] {IDLE, CAND, DIV, CHECK, EMIT, DONE} state_t;
endpackage

// File: rtl/prime_mod_unit.sv
// prime_mod_unit: serial restoring remainder, dividend % divisor in WIDTH cycles
// ports: clk, rst (async, high), go (start pulse), dividend, divisor -> rem, rdy (one-cycle pulse)
module prime_mod_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem,
    output logic             rdy
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] r_q, q_q;
    logic [CW-1:0]    cnt_q;
    logic             act_q;
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] r, input logic b,
                                              input logic [WIDTH-1:0] dv);
        logic [WIDTH:0] t;
        t = {r, b};
        return t >= {1'b0, dv} ? WIDTH'(t - {1'b0, dv}) : WIDTH'(t);
    endfunction
    // the first bit is consumed on the go edge so rdy lands exactly WIDTH cycles after go
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            q_q   <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else if (go) begin
            r_q   <= step('0, dividend[WIDTH-1], divisor);
            q_q   <= dividend << 1;
            cnt_q <= CW'(WIDTH - 1);
            act_q <= 1'b1;
        end else if (act_q) begin
            if (cnt_q != '0) begin
                r_q   <= step(r_q, q_q[WIDTH-1], divisor);
                q_q   <= q_q << 1;
                cnt_q <= cnt_q - 1'b1;
            end else begin
                act_q <= 1'b0;
            end
        end
    end
    assign rem = r_q;
    assign rdy = act_q && cnt_q == '0;
endmodule

// File: rtl/prime_generator.sv
// prime_generator: emits primes 2..limit in ascending order by trial division
// ports: clk, rst (async, high), start, limit, out_ready -> out_valid, prime, busy, done
module prime_generator
    import prime_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] prime,
    output logic             busy,
    output logic             done
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cand_q, cand_d, d_q, d_d, lim_q, lim_d, rem;
    logic [2*WIDTH-1:0] sq;
    logic               go, rdy, last;
    prime_mod_unit #(.WIDTH(WIDTH)) u_mod (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .dividend (cand_q),
        .divisor  (d_q),
        .rem      (rem),
        .rdy      (rdy)
    );
    assign sq   = (2*WIDTH)'(d_q) * (2*WIDTH)'(d_q);
    // stopping at cand==limit keeps cand from wrapping when limit is all ones
    assign last = cand_q == lim_q;
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        d_d     = d_q;
        lim_d   = lim_q;
        go      = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                lim_d   = limit;
                cand_d  = WIDTH'(2);
                d_d     = WIDTH'(2);
                state_d = limit < WIDTH'(2) ? DONE : CAND;
            end
            CAND: if (sq > (2*WIDTH)'(cand_q)) state_d = EMIT;
                  else begin
                      go      = 1'b1;
                      state_d = DIV;
                  end
            DIV: if (rdy) state_d = CHECK;
            CHECK: if (rem != '0) begin
                d_d     = d_q + 1'b1;
                state_d = CAND;
            end else if (last) state_d = DONE;
            else begin
                cand_d  = cand_q + 1'b1;
                d_d     = WIDTH'(2);
                state_d = CAND;
            end
            EMIT: if (out_ready) begin
                if (last) state_d = DONE;
                else begin
                    cand_d  = cand_q + 1'b1;
                    d_d     = WIDTH'(2);
                    state_d = CAND;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= '0;
            d_q     <= '0;
            lim_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            d_q     <= d_d;
            lim_q   <= lim_d;
        end
    end
    assign out_valid = state_q == EMIT;
    assign prime     = state_q == EMIT ? cand_q : '0;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
endmodule

// File: tb/tb_prime_generator.sv
// tb_prime_generator: table-driven sweeps plus stall, reset and restart corner cases
module tb_prime_generator;
    import prime_pkg::*;
    localparam int W = 8;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic [W-1:0] limit = '0, prime;
    logic out_valid, busy, done;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    prime_generator #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .limit(limit), .out_ready(out_ready),
        .out_valid(out_valid), .prime(prime), .busy(busy), .done(done)
    );

    typedef struct {int lim; int cnt; int last; int sum;} vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 0;
        for (int k = 2; k * k <= n; k++) if (n % k == 0) return 0;
        return 1;
    endfunction

    function automatic int next_prime(input int n);
        int p = n + 1;
        while (!is_prime(p)) p++;
        return p;
    endfunction

    task automatic run(input int lim, input int stall_at, input int stall_len, input int inj_at,
                       output int cnt, output int last, output int sum, output int dones,
                       output int obad, output int stalled);
        int prev = 1;
        cnt = 0; last = 0; sum = 0; dones = 0; obad = 0; stalled = 0;
        @(negedge clk);
        limit = W'(lim);
        start = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (int'(prime) == stall_at && stalled < stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    if (int'(prime) != next_prime(prev) || int'(prime) > lim) obad++;
                    prev = int'(prime);
                    cnt++;
                    sum += int'(prime);
                    last = int'(prime);
                end
            end else out_ready = 1'b1;
            start = c == inj_at;
            if (c == inj_at) limit = W'(3);
            if (done) begin
                dones++;
                break;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        chk({tag, " done one cycle"}, int'(done), 0);
        chk({tag, " busy low"}, int'(busy), 0);
        chk({tag, " valid low"}, int'(out_valid), 0);
    endtask

    initial begin
        int cnt, last, sum, dones, obad, stalled, seen;
        vecs[0] = '{10, 4, 7, 17};
        vecs[1] = '{1, 0, 0, 0};
        vecs[2] = '{0, 0, 0, 0};
        vecs[3] = '{2, 1, 2, 2};
        vecs[4] = '{13, 6, 13, 41};
        vecs[5] = '{255, 54, 251, 6081};

        #12;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset prime", int'(prime), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run(vecs[i].lim, -1, 0, -1, cnt, last, sum, dones, obad, stalled);
            chk($sformatf("lim%0d count", vecs[i].lim), cnt, vecs[i].cnt);
            chk($sformatf("lim%0d last", vecs[i].lim), last, vecs[i].last);
            chk($sformatf("lim%0d sum", vecs[i].lim), sum, vecs[i].sum);
            chk($sformatf("lim%0d done pulses", vecs[i].lim), dones, 1);
            chk($sformatf("lim%0d order", vecs[i].lim), obad, 0);
            after_done($sformatf("lim%0d", vecs[i].lim));
        end

        run(13, 3, 5, -1, cnt, last, sum, dones, obad, stalled);
        chk("stall cycles held at 3", stalled, 5);
        chk("stall count", cnt, 6);
        chk("stall order", obad, 0);
        chk("stall last", last, 13);
        chk("stall done", dones, 1);
        after_done("stall");

        run(20, -1, 0, 30, cnt, last, sum, dones, obad, stalled);
        chk("restart-ignored count", cnt, 8);
        chk("restart-ignored last", last, 19);
        chk("restart-ignored sum", sum, 77);
        chk("restart-ignored order", obad, 0);
        chk("restart-ignored done", dones, 1);
        after_done("restart-ignored");

        @(negedge clk);
        limit = W'(20);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 2000; c++) begin
            if (dut.state_q == DIV && int'(dut.cand_q) == 9) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("reached DIV on 9", seen, 1);
        rst = 1'b1;
        #1;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst prime", int'(prime), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst state", int'(dut.state_q), int'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid || busy || done) seen++;
        end
        chk("quiet after reset", seen, 0);
        run(5, -1, 0, -1, cnt, last, sum, dones, obad, stalled);
        chk("post-reset count", cnt, 3);
        chk("post-reset last", last, 5);
        chk("post-reset sum", sum, 10);
        chk("post-reset order", obad, 0);
        chk("post-reset done", dones, 1);
        after_done("post-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
